// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a byte FIFO, status register and drop-on-full overflow flag.
// Optional even-parity bit after the data bits when UART_PARITY_EN is defined.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        io_sel,
  output logic [31:0] io_rdata,
  output logic        txd
);

  localparam int unsigned   CW          = $clog2(CLKS_PER_BIT);
  localparam int unsigned   AW          = $clog2(FIFO_DEPTH);
  localparam int unsigned   PW          = AW + 1;
  localparam logic [31:0]   STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [CW-1:0] BAUD_RELOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  // Bus decode
  logic w_hit_data;
  logic w_hit_status;
  logic w_push_req;
  logic w_ovf_clr;
  logic w_unused;

  assign w_hit_data   = (dataadr[31:2] == BASE_ADDR[31:2]);
  assign w_hit_status = (dataadr[31:2] == STATUS_ADDR[31:2]);
  assign w_push_req   = memwrite && w_hit_data;
  assign w_ovf_clr    = memwrite && w_hit_status && writedata[3];
  assign w_unused     = ^{dataadr[1:0], writedata[31:8]};

  // FIFO storage and pointers with an extra wrap bit
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_head;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign w_push  = w_push_req && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= writedata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set
  logic r_ovf;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_push_req && !w_push) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // Transmit FSM registers
  state_t        r_state;
  logic [CW-1:0] r_baud;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic          r_parity;
  logic          r_txd;

  state_t        w_state_next;
  logic [CW-1:0] w_baud_next;
  logic [2:0]    w_bit_next;
  logic [7:0]    w_shift_next;
  logic          w_parity_next;
  logic          w_txd_next;
  logic          w_baud_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_parity  <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_baud    <= w_baud_next;
      r_bit_cnt <= w_bit_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_txd     <= w_txd_next;
    end
  end

  // Next state; txd is computed from the next state so it lines up with it
  always_comb begin
    w_state_next  = r_state;
    w_baud_next   = r_baud;
    w_bit_next    = r_bit_cnt;
    w_shift_next  = r_shift;
    w_parity_next = r_parity;
    w_pop         = 1'b0;
    w_txd_next    = 1'b1;
    w_baud_done   = (r_baud == '0);

    if (r_state != S_IDLE) begin
      w_baud_next = w_baud_done ? BAUD_RELOAD : (r_baud - CW'(1));
    end

    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_state_next  = S_START;
          w_baud_next   = BAUD_RELOAD;
          w_shift_next  = w_head;
          w_parity_next = ^w_head;
        end
      end
      S_START: begin
        if (w_baud_done) begin
          w_state_next = S_DATA;
          w_bit_next   = 3'd0;
        end
      end
      S_DATA: begin
        if (w_baud_done) begin
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit_cnt == 3'd7) begin
            w_bit_next   = 3'd0;
`ifdef UART_PARITY_EN
            w_state_next = S_PARITY;
`else
            w_state_next = S_STOP;
`endif
          end else begin
            w_bit_next = r_bit_cnt + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (w_baud_done) begin
          w_state_next = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_baud_done) begin
          if (!w_empty) begin
            w_pop         = 1'b1;
            w_state_next  = S_START;
            w_shift_next  = w_head;
            w_parity_next = ^w_head;
          end else begin
            w_state_next = S_IDLE;
            w_baud_next  = '0;
          end
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_baud_next  = '0;
        w_bit_next   = 3'd0;
      end
    endcase

    case (w_state_next)
      S_START:  w_txd_next = 1'b0;
      S_DATA:   w_txd_next = w_shift_next[0];
`ifdef UART_PARITY_EN
      S_PARITY: w_txd_next = w_parity_next;
`endif
      default:  w_txd_next = 1'b1;
    endcase
  end

  // Read port and outputs
  logic w_busy;

  assign w_busy   = (r_state != S_IDLE);
  assign io_sel   = (dataadr[31:3] == BASE_ADDR[31:3]);
  assign io_rdata = w_hit_status ? {28'b0, r_ovf, w_empty, w_full, w_busy} : 32'h0;
  assign txd      = r_txd;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboard bench for mmio_uart_tx: a cycle-count model predicts accepted bytes and frame start
// times; an independent serial receiver pops and compares each frame. Honors UART_PARITY_EN.
module tb_mmio_uart_tx;

  localparam int C = 4;
  localparam int D = 4;
  localparam logic [31:0] BASE = 32'h0000_0100;
  localparam logic [31:0] STAT = 32'h0000_0104;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * C;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = 32'h0;
  logic [31:0] writedata = 32'h0;
  logic        io_sel;
  logic [31:0] io_rdata;
  logic        txd;

  mmio_uart_tx #(
    .CLKS_PER_BIT(C),
    .FIFO_DEPTH  (D),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .memwrite (memwrite),
    .dataadr  (dataadr),
    .writedata(writedata),
    .io_sel   (io_sel),
    .io_rdata (io_rdata),
    .txd      (txd)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Reference model: FIFO contents plus cycles left in the frame on the wire
  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_q[$];
  int         m_rem = 0;
  bit         m_ovf = 1'b0;
  int         cyc = 0;
  bit         m_pop;
  exp_t       m_e;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_rem = 0;
      m_ovf = 1'b0;
    end else begin
      cyc++;
      m_pop = (m_rem <= 1) && (m_q.size() != 0);
      if (m_pop) begin
        m_e.data = m_q.pop_front();
        m_e.cyc  = cyc;
        exp_q.push_back(m_e);
        m_rem = FRAME;
      end else if (m_rem != 0) begin
        m_rem--;
      end
      if (memwrite && dataadr[31:2] == BASE[31:2]) begin
        if (m_q.size() < D) m_q.push_back(writedata[7:0]);
        else m_ovf = 1'b1;
      end else if (memwrite && dataadr[31:2] == STAT[31:2] && writedata[3]) begin
        m_ovf = 1'b0;
      end
    end
  end

  function automatic logic [31:0] exp_rdata(input logic [31:0] a);
    if (a[31:2] == STAT[31:2])
      return {28'b0, m_ovf, m_q.size() == 0, m_q.size() == D, m_rem != 0};
    return 32'h0;
  endfunction

  // Serial receiver: detects start, samples mid-bit, compares with scoreboard head
  bit         mon_act = 1'b0;
  int         mon_cnt = 0;
  int         mon_idx;
  logic [7:0] mon_byte;
  logic [7:0] mon_exp;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (txd == 1'b0) begin
        mon_act  = 1'b1;
        mon_cnt  = 0;
        mon_byte = 8'h0;
        mon_exp  = 8'h0;
        check(exp_q.size() != 0, "unexpected_start", 32'(exp_q.size()), 32'd1);
        if (exp_q.size() != 0) begin
          mon_e   = exp_q.pop_front();
          mon_exp = mon_e.data;
          check(cyc == mon_e.cyc, "start_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % C == C / 2) begin
        mon_idx = mon_cnt / C;
        if (mon_idx == 0) begin
          check(txd == 1'b0, "start_bit", 32'(txd), 32'd0);
        end else if (mon_idx <= 8) begin
          mon_byte = {txd, mon_byte[7:1]};
`ifdef UART_PARITY_EN
        end else if (mon_idx == 9) begin
          check(txd == ^mon_exp, "parity_bit", 32'(txd), 32'(^mon_exp));
`endif
        end else begin
          check(txd == 1'b1, "stop_bit", 32'(txd), 32'd1);
          check(mon_byte == mon_exp, "frame_data", 32'(mon_byte), 32'(mon_exp));
          mon_act = 1'b0;
        end
      end
    end
  end

  // One bus cycle, with the combinational read port checked against the model
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    memwrite  = we;
    dataadr   = a;
    writedata = d;
    #1;
    check(io_sel == (a[31:3] == BASE[31:3]), "io_sel", 32'(io_sel), 32'(a[31:3] == BASE[31:3]));
    check(io_rdata == exp_rdata(a), "io_rdata", io_rdata, exp_rdata(a));
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, STAT, 32'h0);
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 4))
      0:       return BASE;
      1:       return STAT;
      2:       return 32'h0000_00FC;
      3:       return 32'h0000_0108;
      default: return $urandom;
    endcase
  endfunction

  int rates[6] = '{2, 5, 10, 30, 60, 5};
  int r;

  initial begin
    rst_n = 1'b0;
    cycle(1'b0, STAT, 32'h0);
    check(txd == 1'b1, "txd_in_reset", 32'(txd), 32'd1);
    check(io_rdata == 32'h4, "status_in_reset", io_rdata, 32'h4);
    @(negedge clk);
    rst_n = 1'b1;

    // Single frame
    cycle(1'b1, BASE, 32'h55);
    idle(50);

    // Back-to-back frames
    cycle(1'b1, BASE, 32'hA3);
    cycle(1'b1, BASE, 32'h0F);
    idle(90);

    // Overflow: six writes during one frame, then clear
    for (int i = 0; i < 6; i++) cycle(1'b1, BASE, 32'(8'h10 + i));
    cycle(1'b0, STAT, 32'h0);
    check(io_rdata[3] == 1'b1, "ovf_set", io_rdata, 32'h8);
    cycle(1'b1, STAT, 32'h8);
    cycle(1'b0, STAT, 32'h0);
    check(io_rdata[3] == 1'b0, "ovf_cleared", io_rdata, 32'h0);
    idle(6 * FRAME);

    // Asynchronous reset during data bit 3 of 0x05
    cycle(1'b1, BASE, 32'h05);
    repeat (18) cycle(1'b0, STAT, 32'h0);
    @(negedge clk);
    #1;
    check(txd == 1'b0, "bit3_before_reset", 32'(txd), 32'd0);
    rst_n = 1'b0;
    #1;
    check(txd == 1'b1, "txd_async_reset", 32'(txd), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cycle(1'b0, STAT, 32'h0);
    check(io_rdata == 32'h4, "status_after_reset", io_rdata, 32'h4);
    idle(2 * FRAME);

    // Non-hit addresses
    cycle(1'b0, 32'h0000_00FC, 32'h0);
    cycle(1'b1, 32'h0000_00FC, 32'h55);
    cycle(1'b1, 32'h0000_0108, 32'h55);
    idle(2 * FRAME);
    check(txd == 1'b1, "txd_idle_nonhit", 32'(txd), 32'd1);

    // Randomized traffic at varying write rates
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 400; i++) begin
        r = int'($urandom_range(0, 99));
        if (r < rates[p]) cycle(1'b1, BASE, $urandom);
        else if (r < rates[p] + 4) cycle(1'b1, STAT, $urandom);
        else if (r < rates[p] + 6) cycle(1'b1, pick_addr(), $urandom);
        else cycle(1'b0, pick_addr(), $urandom);
      end
    end

    // Drain
    for (int i = 0; i < 3000 && !(m_q.size() == 0 && m_rem == 0); i++) idle(1);
    check(m_q.size() == 0 && m_rem == 0, "drain_timeout", 32'(m_rem), 32'd0);
    idle(5);
    check(exp_q.size() == 0 && !mon_act, "frames_outstanding", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
